// File: rtl/bcd_conv_arbiter_if.sv
// rtl/bcd_conv_arbiter_if.sv - requester, response and converter signal bundle for bcd_conv_arbiter
//
// Purpose: groups the requester handshake, the shared response bus and the
// link to the single binary-to-BCD converter into one interface.
//
// Signals:
//   req_valid  [NREQ]    per-requester conversion request
//   req_bin    [NREQ*N]  operands, requester k at bits [k*N +: N]
//   req_ready  [NREQ]    one-hot accept pulse
//   rsp_valid  [NREQ]    one-hot response valid
//   rsp_ready  [NREQ]    per-requester response accept
//   rsp_bcd    [16]      result digits {d3,d2,d1,d0}, shared by all requesters
//   rsp_err    [1]       response is a timeout abort
//   conv_start [1]       start pulse to the converter
//   conv_bin   [N]       operand to the converter
//   conv_done  [1]       converter done level
//   conv_bcd   [16]      converter digits {bcd3,bcd2,bcd1,bcd0}
//
// Modports: slave is the arbiter's view, master is the requester/converter side.

interface bcd_conv_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [15:0]       rsp_bcd;
  logic              rsp_err;
  logic              conv_start;
  logic [N-1:0]      conv_bin;
  logic              conv_done;
  logic [15:0]       conv_bcd;

  modport slave (
    input  req_valid,
    input  req_bin,
    input  rsp_ready,
    input  conv_done,
    input  conv_bcd,
    output req_ready,
    output rsp_valid,
    output rsp_bcd,
    output rsp_err,
    output conv_start,
    output conv_bin
  );

  modport master (
    output req_valid,
    output req_bin,
    output rsp_ready,
    output conv_done,
    output conv_bcd,
    input  req_ready,
    input  rsp_valid,
    input  rsp_bcd,
    input  rsp_err,
    input  conv_start,
    input  conv_bin
  );

endinterface

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin arbiter sharing one binary-to-BCD converter
//
// Purpose: picks one of NREQ requesters round-robin, loads its operand into the
// shared converter, pulses start, waits for a rising edge of conv_done (or a
// watchdog timeout) and returns the 4-digit BCD result to the winner over a
// valid/ready handshake.
//
// Ports:
//   clk  input  clock
//   rst  input  asynchronous reset, active-low
//   bus  bcd_conv_arbiter_if.slave  requester, response and converter signals
//
// Parameters:
//   N        operand width, must match the converter
//   NREQ     number of requesters (2..8)
//   TIMEOUT  maximum cycles spent waiting for the converter (>= N+4)

module bcd_conv_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_conv_arbiter_if.slave      bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [N-1:0]      conv_bin_q, conv_bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_bcd_q, rsp_bcd_d;
  logic              rsp_err_q, rsp_err_d;

  logic [IW-1:0]     pick;
  logic              pick_found;
  logic [IW:0]       cand;
  logic [N-1:0]      pick_bin;
  logic [NREQ-1:0]   grant_onehot;
  logic              done_edge;
  logic              timeout_hit;

  // Round-robin search: start one above the last winner and wrap, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!pick_found && bus.req_valid[cand[IW-1:0]]) begin
        pick       = cand[IW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_bin = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == IW'(k)) begin
        pick_bin = bus.req_bin[k*N +: N];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      grant_onehot[k] = (grant_q == IW'(k));
    end
  end

  // Only a fresh rising edge counts; a done level left high by the previous
  // conversion is filtered because done_q tracks conv_done in every state.
  assign done_edge   = bus.conv_done & ~done_q;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    conv_bin_d  = conv_bin_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bcd_d   = rsp_bcd_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d    = pick;
          conv_bin_d = pick_bin;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        ptr_d   = grant_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Completion is tested first so it wins a tie with the watchdog.
        if (done_edge) begin
          rsp_bcd_d   = bus.conv_bcd;
          rsp_err_d   = 1'b0;
          rsp_valid_d = grant_onehot;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          rsp_bcd_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_onehot;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        // rsp_valid_q is one-hot on the winner, so this ignores other channels.
        if ((rsp_valid_q & bus.rsp_ready) != '0) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= IW'(NREQ - 1);
      conv_bin_q  <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_bcd_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      conv_bin_q  <= conv_bin_d;
      cnt_q       <= cnt_d;
      done_q      <= bus.conv_done;
      rsp_valid_q <= rsp_valid_d;
      rsp_bcd_q   <= rsp_bcd_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // The accept and the start pulse are the ISSUE cycle itself.
  assign bus.req_ready  = (state_q == S_ISSUE) ? grant_onehot : '0;
  assign bus.conv_start = (state_q == S_ISSUE);
  assign bus.conv_bin   = conv_bin_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_bcd    = rsp_bcd_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - scoreboard bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  bcd_conv_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [7:0]  bin;
    logic [15:0] bcd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   conv_mode  = 0;  // 0 normal, 1 stuck low, 2 stale done level
  int   conv_delay = 10;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [7:0] b);
    return {4'd0, 4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  // Converter model
  logic [7:0] cb;
  initial begin
    bus.conv_done = 1'b0;
    bus.conv_bcd  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.conv_start) begin
        cb = bus.conv_bin;
        if (conv_mode == 0) begin
          repeat (conv_delay) @(posedge clk);
          #1; bus.conv_done = 1'b1; bus.conv_bcd = to_bcd(cb);
          @(posedge clk); #1; bus.conv_done = 1'b0;
        end else if (conv_mode == 2) begin
          bus.conv_done = 1'b1; bus.conv_bcd = 16'hDEAD;
          repeat (2) @(posedge clk);
          #1; bus.conv_done = 1'b0;
          repeat (12) @(posedge clk);
          #1; bus.conv_done = 1'b1; bus.conv_bcd = to_bcd(cb);
          @(posedge clk); #1; bus.conv_done = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  int              m_cyc = 0;
  int              m_start_cyc = 0;
  logic            m_prev_start = 1'b0;
  logic [NREQ-1:0] m_prev_valid = '0;
  logic            m_acc_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!rst) begin
        m_prev_start = 1'b0;
        m_prev_valid = '0;
        m_acc_prev   = 1'b0;
      end else begin
        if (m_acc_prev) check("rsp_valid_drop", bus.rsp_valid, 0);
        m_acc_prev = 1'b0;
        if (bus.conv_start) begin
          check("conv_start_width", m_prev_start, 0);
          m_start_cyc = m_cyc;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: req_ready %0h, required no start", bus.req_ready);
          end else begin
            check("req_ready", bus.req_ready, 1 << exp_q[0].idx);
            check("conv_bin", bus.conv_bin, exp_q[0].bin);
          end
        end
        if (bus.rsp_valid != '0) begin
          check("start_during_rsp", bus.conv_start, 0);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: rsp_valid %0h, required 0", bus.rsp_valid);
          end else begin
            if (m_prev_valid == '0) check("latency", m_cyc - m_start_cyc, exp_q[0].lat);
            check("rsp_valid", bus.rsp_valid, 1 << exp_q[0].idx);
            check("rsp_bcd", bus.rsp_bcd, exp_q[0].bcd);
            check("rsp_err", bus.rsp_err, exp_q[0].err);
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
              void'(exp_q.pop_front());
              m_acc_prev = 1'b1;
            end
          end
        end
        m_prev_start = bus.conv_start;
        m_prev_valid = bus.rsp_valid;
      end
    end
  end

  // Stimulus
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic push(int idx, logic [7:0] bin, logic [15:0] bcd, logic err, int lat);
    exp_t e;
    e.idx = idx; e.bin = bin; e.bcd = bcd; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic req(int k, logic [7:0] bin);
    bus.req_bin[k*N +: N] = bin;
    bus.req_valid[k]      = 1'b1;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.req_valid != '0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d responses pending after %0d cycles, required 0", name, exp_q.size(), n);
    end
    step();
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    bus.req_valid = '0;
    @(negedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_req_ready"},  bus.req_ready,  0);
    check({tag, "_rsp_valid"},  bus.rsp_valid,  0);
    check({tag, "_rsp_bcd"},    bus.rsp_bcd,    0);
    check({tag, "_rsp_err"},    bus.rsp_err,    0);
    check({tag, "_conv_start"}, bus.conv_start, 0);
    check({tag, "_conv_bin"},   bus.conv_bin,   0);
  endtask

  initial begin
    int n;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_bin   = '0;
    bus.rsp_ready = '1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 rst = 1'b1;

    // Single request, done edge 10 cycles after start
    conv_delay = 10;
    push(0, 8'd255, 16'h0255, 1'b0, 11);
    req(0, 8'd255);
    drain("single", 100);

    // Round-robin from reset, then wrap back to requester 0
    do_reset();
    conv_delay = 3;
    push(0, 8'd0,   16'h0000, 1'b0, 4);
    push(1, 8'd9,   16'h0009, 1'b0, 4);
    push(2, 8'd100, 16'h0100, 1'b0, 4);
    push(3, 8'd200, 16'h0200, 1'b0, 4);
    req(0, 8'd0); req(1, 8'd9); req(2, 8'd100); req(3, 8'd200);
    drain("rr", 200);
    push(0, 8'd42,  16'h0042, 1'b0, 4);
    push(2, 8'd137, 16'h0137, 1'b0, 4);
    req(0, 8'd42); req(2, 8'd137);
    drain("rr_wrap", 100);

    // Stale done level, real edge 12 cycles after the fall
    conv_mode = 2;
    push(1, 8'd99, 16'h0099, 1'b0, 15);
    req(1, 8'd99);
    drain("stale", 100);
    conv_mode = 0;

    // Watchdog abort, then a normal conversion
    conv_mode = 1;
    push(1, 8'd77, 16'h0000, 1'b1, TIMEOUT + 1);
    req(1, 8'd77);
    drain("timeout", 200);
    conv_mode  = 0;
    conv_delay = 10;
    push(3, 8'd58, 16'h0058, 1'b0, 11);
    req(3, 8'd58);
    drain("after_timeout", 100);

    // Backpressure on requester 2 while requester 0 waits
    do_reset();
    push(2, 8'd123, 16'h0123, 1'b0, 11);
    push(0, 8'd250, 16'h0250, 1'b0, 11);
    bus.rsp_ready = 4'b0001;
    req(2, 8'd123);
    n = 0;
    while (!bus.rsp_valid[2] && n < 100) begin step(); n++; end
    check("bp_reach_resp", bus.rsp_valid[2], 1);
    req(0, 8'd250);
    repeat (10) step();
    check("bp_held", bus.rsp_valid, 4'b0100);
    bus.rsp_ready = 4'b0101;
    drain("bp", 200);
    bus.rsp_ready = '1;

    // Reset while waiting on the converter
    push(2, 8'd64, 16'h0064, 1'b0, 11);
    req(2, 8'd64);
    n = 0;
    while (!bus.conv_start && n < 50) begin step(); n++; end
    repeat (3) step();
    @(negedge clk); #2;
    rst = 1'b0;
    #1 check_zero("rst_wait");
    exp_q.delete();
    bus.req_valid = '0;
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (15) step();
    push(0, 8'd1, 16'h0001, 1'b0, 11);
    push(1, 8'd2, 16'h0002, 1'b0, 11);
    req(0, 8'd1); req(1, 8'd2);
    drain("post_reset", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one binary-to-BCD converter between NREQ requesters, e.g. several display channels or counters feeding a 4-digit seven-segment front end.
- Arbitrates round-robin, loads the winner's operand into the converter, pulses start, and waits for a done edge.
- Returns the 4-digit BCD result to the winning requester over a valid/ready handshake.
- A watchdog aborts a conversion that never completes and flags an error.

Parameters:
- N, 8, operand width in bits; must match the converter's N.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 63, maximum cycles spent in WAIT before abort (≥ N+4).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  NREQ  per-requester conversion request.
- req_bin  input  NREQ*N  operands; requester k occupies bits [k*N +: N].
- req_ready  output  NREQ  one-hot accept pulse.
- rsp_valid  output  NREQ  one-hot response valid.
- rsp_ready  input  NREQ  per-requester response accept.
- rsp_bcd  output  16  result digits {d3,d2,d1,d0}, shared by all requesters.
- rsp_err  output  1  response is a timeout abort.
- conv_start  output  1  start pulse to converter.
- conv_bin  output  N  operand to converter.
- conv_done  input  1  converter done.
- conv_bcd  input  16  converter digits {bcd3,bcd2,bcd1,bcd0}.

Behaviour:
- Reset (rst low, any state, asynchronous): state IDLE; req_ready=0, rsp_valid=0, rsp_bcd=0, rsp_err=0, conv_start=0, conv_bin=0; round-robin pointer=NREQ-1 so requester 0 wins first; timeout counter=0; done_q=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the first requester above the pointer, searching with wrap.
  - Register grant index g; register conv_bin = req_bin[g]; go to ISSUE.
  - A request that drops before the grant is not latched.
- ISSUE (exactly 1 cycle):
  - conv_start=1, req_ready[g]=1; this cycle is the accept.
  - Pointer updates to g.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - done_q registers conv_done every cycle; completion is defined as conv_done & ~done_q (rising edge).
  - A done level left high from a previous conversion is ignored.
  - On completion: latch rsp_bcd=conv_bcd, rsp_err=0, go to RESP.
  - Otherwise the counter increments. At counter==TIMEOUT-1 without completion: rsp_bcd=0, rsp_err=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid[g]=1; rsp_bcd and rsp_err are held stable.
  - When rsp_ready[g]=1: drop rsp_valid next cycle and return to IDLE.
  - rsp_ready on other channels is ignored.
- Throughput:
  - Minimum request-to-accept latency: 2 cycles (IDLE then ISSUE).
  - Back-to-back conversions need one IDLE cycle between RESP and the next ISSUE.
- Fairness: a requester holding req_valid waits at most NREQ-1 other conversions.
- Outputs are registered except req_ready and conv_start, which are decoded from state and g.
- conv_bin holds its value from IDLE exit until the next grant.

Test Plan:
- Single request: N=8, requester 0, bin=8'd255, converter done edge after 10 cycles -> req_ready[0] pulses once; conv_start is a 1-cycle pulse; rsp_valid[0]=1 with rsp_bcd=16'h0255, rsp_err=0 until rsp_ready[0].
- Round-robin: all 4 requesters valid after reset with bins 0, 9, 100, 200 -> grant order 0,1,2,3; rsp_bcd = 16'h0000, 16'h0009, 16'h0100, 16'h0200; then requester 0 re-served.
- Stale done: conv_done held high entering WAIT, falls, rises 12 cycles later -> completion only on the new rising edge.
- Timeout: conv_done stuck low -> exactly 63 cycles in WAIT, then rsp_err=1, rsp_bcd=0; the next request proceeds normally.
- Backpressure: rsp_ready[2] low for 10 cycles with rsp_ready[0]=1 -> rsp_valid[2] and rsp_bcd stay stable; no new conv_start until rsp_ready[2] is accepted.
- Reset in WAIT: rst low for 1 cycle mid-conversion -> all outputs 0 immediately; after release, requester 0 is granted first.
